commit_arbiter: RTL and testbench

- Consumer end of the execution-unit commiter interface (res / o_rd / valid / o_error / req / clear).
- Arbitrates round-robin among NUM_UNITS execution units holding finished results.
- Retires one result per cycle to the register-file write port and pulses clear back to the granted unit.
- On a unit error it raises an exception record and halts commits until acknowledged.

---
 rtl/commit_arbiter.sv | 136 +++++++++++++
 tb/tb_commit_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/commit_arbiter.sv
// rtl/commit_arbiter.sv - round-robin commit arbiter retiring execution-unit results to the register file
// Optional statistics counters enabled by defining COMMIT_ARBITER_STATS_EN.
package core_config_pkg;
  parameter int XLEN       = 32;
  parameter int REG_ADDR_W = 5;
endpackage

module commit_arbiter #(
  parameter int NUM_UNITS  = 4,
  parameter int XLEN       = core_config_pkg::XLEN,
  parameter int REG_ADDR_W = core_config_pkg::REG_ADDR_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_UNITS*XLEN-1:0]       u_res,
  input  logic [NUM_UNITS*REG_ADDR_W-1:0] u_rd,
  input  logic [NUM_UNITS-1:0]            u_valid,
  input  logic [NUM_UNITS-1:0]            u_error,
  input  logic [NUM_UNITS-1:0]            u_req,
  output logic [NUM_UNITS-1:0]            u_clear,
  output logic                            wb_we,
  output logic [REG_ADDR_W-1:0]           wb_addr,
  output logic [XLEN-1:0]                 wb_data,
  output logic                            exc_valid,
  output logic [$clog2(NUM_UNITS)-1:0]    exc_unit,
  output logic [REG_ADDR_W-1:0]           exc_rd,
  input  logic                            exc_ack,
`ifdef COMMIT_ARBITER_STATS_EN
  output logic [31:0]                     stat_commits,
  output logic [31:0]                     stat_conflicts,
`endif
  output logic                            halted
);

  localparam int UW = $clog2(NUM_UNITS);

  typedef enum logic {RUN, HALT} state_t;

  state_t                 state;
  logic [UW-1:0]          ptr;
  logic [UW-1:0]          gnt;
  logic [UW-1:0]          ptr_next;
  logic [NUM_UNITS-1:0]   mask;
  logic [NUM_UNITS-1:0]   cand;
  logic [NUM_UNITS-1:0]   gnt_onehot;
  logic                   found;
  logic [REG_ADDR_W-1:0]  sel_rd;
  logic [XLEN-1:0]        sel_res;
  logic                   sel_err;

  // The unit granted last cycle still holds req while its clear is in flight, so it is masked.
  always_comb begin
    cand  = u_req & u_valid & ~mask;
    found = 1'b0;
    gnt   = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (!found && cand[i] && (UW'(i) >= ptr)) begin
        found = 1'b1;
        gnt   = UW'(i);
      end
    end
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (!found && cand[i]) begin
        found = 1'b1;
        gnt   = UW'(i);
      end
    end
    gnt_onehot = NUM_UNITS'(1) << gnt;
    ptr_next   = (gnt == UW'(NUM_UNITS - 1)) ? '0 : gnt + 1'b1;
    sel_rd     = u_rd[gnt*REG_ADDR_W +: REG_ADDR_W];
    sel_res    = u_res[gnt*XLEN +: XLEN];
    sel_err    = u_error[gnt];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      ptr       <= '0;
      mask      <= '0;
      u_clear   <= '0;
      wb_we     <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
      exc_valid <= 1'b0;
      exc_unit  <= '0;
      exc_rd    <= '0;
      halted    <= 1'b0;
`ifdef COMMIT_ARBITER_STATS_EN
      stat_commits   <= '0;
      stat_conflicts <= '0;
`endif
    end else begin
      u_clear <= '0;
      wb_we   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
      case (state)
        RUN: begin
          mask <= '0;
`ifdef COMMIT_ARBITER_STATS_EN
          if ((cand & (cand - 1'b1)) != '0) stat_conflicts <= stat_conflicts + 32'd1;
`endif
          if (found) begin
            u_clear <= gnt_onehot;
            mask    <= gnt_onehot;
            ptr     <= ptr_next;
            if (sel_err) begin
              exc_valid <= 1'b1;
              exc_unit  <= gnt;
              exc_rd    <= sel_rd;
              halted    <= 1'b1;
              state     <= HALT;
            end else begin
              wb_we   <= (sel_rd != '0);
              wb_addr <= sel_rd;
              wb_data <= sel_res;
`ifdef COMMIT_ARBITER_STATS_EN
              stat_commits <= stat_commits + 32'd1;
`endif
            end
          end
        end
        HALT: begin
          mask <= '0;
          if (exc_ack) begin
            exc_valid <= 1'b0;
            halted    <= 1'b0;
            state     <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_commit_arbiter.sv
// tb/tb_commit_arbiter.sv - directed and randomized checks of commit_arbiter against a reference model
// Stats checks are compiled in when COMMIT_ARBITER_STATS_EN is defined.
module tb_commit_arbiter;
  localparam int N  = 4;
  localparam int XW = 32;
  localparam int RW = 5;
  localparam int UW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*XW-1:0] u_res;
  logic [N*RW-1:0] u_rd;
  logic [N-1:0]    u_valid, u_error, u_req, u_clear;
  logic            wb_we, exc_valid, exc_ack, halted;
  logic [RW-1:0]   wb_addr, exc_rd;
  logic [XW-1:0]   wb_data;
  logic [UW-1:0]   exc_unit;
`ifdef COMMIT_ARBITER_STATS_EN
  logic [31:0]     stat_commits, stat_conflicts;
`endif

  always #5 clk = ~clk;

  commit_arbiter #(.NUM_UNITS(N), .XLEN(XW), .REG_ADDR_W(RW)) dut (
    .clk(clk), .rst(rst), .u_res(u_res), .u_rd(u_rd), .u_valid(u_valid),
    .u_error(u_error), .u_req(u_req), .u_clear(u_clear), .wb_we(wb_we),
    .wb_addr(wb_addr), .wb_data(wb_data), .exc_valid(exc_valid),
    .exc_unit(exc_unit), .exc_rd(exc_rd), .exc_ack(exc_ack),
`ifdef COMMIT_ARBITER_STATS_EN
    .stat_commits(stat_commits), .stat_conflicts(stat_conflicts),
`endif
    .halted(halted)
  );

  // Unit-side stimulus
  logic [XW-1:0] res_a [N];
  logic [RW-1:0] rd_a  [N];
  logic [N-1:0]  req, valid, err;

  // Reference model state and expected outputs
  int            m_ptr;
  logic [N-1:0]  m_mask;
  bit            m_halt;
  logic [N-1:0]  e_clear;
  bit            e_we, e_exc;
  logic [RW-1:0] e_addr, e_rd;
  logic [XW-1:0] e_data;
  logic [UW-1:0] e_unit;
  logic [31:0]   e_commits, e_conf;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_cycle();
    int g;
    logic [N-1:0] cand;
    if (rst) begin
      m_ptr = 0; m_mask = '0; m_halt = 0;
      e_clear = '0; e_we = 0; e_addr = '0; e_data = '0;
      e_exc = 0; e_unit = '0; e_rd = '0; e_commits = '0; e_conf = '0;
    end else if (m_halt) begin
      e_clear = '0; e_we = 0; e_addr = '0; e_data = '0; m_mask = '0;
      if (exc_ack) begin e_exc = 0; m_halt = 0; end
    end else begin
      cand = req & valid & ~m_mask;
      if ($countones(cand) >= 2) e_conf = e_conf + 32'd1;
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && cand[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      e_clear = '0; e_we = 0; e_addr = '0; e_data = '0;
      if (g >= 0) begin
        e_clear[g] = 1'b1;
        m_ptr = (g + 1) % N;
        if (err[g]) begin
          e_exc = 1; e_unit = UW'(g); e_rd = rd_a[g]; m_halt = 1;
        end else begin
          e_we = (rd_a[g] != 0); e_addr = rd_a[g]; e_data = res_a[g];
          e_commits = e_commits + 32'd1;
        end
      end
      m_mask = e_clear;
    end
  endtask

  task automatic step();
    for (int i = 0; i < N; i++) begin
      u_res[i*XW +: XW] = res_a[i];
      u_rd[i*RW +: RW]  = rd_a[i];
    end
    u_req = req; u_valid = valid; u_error = err;
    model_cycle();
    @(posedge clk);
    #1;
    chk("u_clear", u_clear, e_clear);
    chk("wb_we", wb_we, e_we);
    chk("wb_addr", wb_addr, e_addr);
    chk("wb_data", wb_data, e_data);
    chk("exc_valid", exc_valid, e_exc);
    chk("exc_unit", exc_unit, e_unit);
    chk("exc_rd", exc_rd, e_rd);
    chk("halted", halted, m_halt);
`ifdef COMMIT_ARBITER_STATS_EN
    chk("stat_commits", stat_commits, e_commits);
    chk("stat_conflicts", stat_conflicts, e_conf);
`endif
  endtask

  // A unit drops its request once it has seen its clear
  task automatic react();
    for (int i = 0; i < N; i++)
      if (e_clear[i]) begin req[i] = 0; valid[i] = 0; err[i] = 0; end
  endtask

  task automatic load(input int i, input logic [XW-1:0] r, input logic [RW-1:0] d, input bit e);
    res_a[i] = r; rd_a[i] = d; err[i] = e; req[i] = 1; valid[i] = 1;
  endtask

  task automatic do_reset();
    rst = 1; step(); rst = 0;
  endtask

  initial begin
    rst = 1; exc_ack = 0; req = '0; valid = '0; err = '0;
    for (int i = 0; i < N; i++) begin res_a[i] = '0; rd_a[i] = '0; end

    // Reset state
    do_reset();
    chk("reset_clear", u_clear, 4'b0000);
    chk("reset_halted", halted, 1'b0);

    // Single unit commit
    load(1, 32'hDEADBEEF, 5'd5, 0);
    step();
    chk("single_we", wb_we, 1'b1);
    chk("single_addr", wb_addr, 5'd5);
    chk("single_data", wb_data, 32'hDEADBEEF);
    chk("single_clear", u_clear, 4'b0010);
    react(); step();
    chk("single_no_more", wb_we, 1'b0);

    // All four from reset: strict order 0..3
    do_reset();
    for (int i = 0; i < N; i++) load(i, 32'h100 + i, RW'(i + 1), 0);
    for (int i = 0; i < N; i++) begin
      step();
      chk("rr_order", u_clear, 4'b0001 << i);
      react();
    end
    step();
    chk("rr_drained", u_clear, 4'b0000);

    // rd = 0 suppresses the write but still clears
    load(2, 32'h1234, 5'd0, 0);
    step();
    chk("rd0_clear", u_clear, 4'b0100);
    chk("rd0_we", wb_we, 1'b0);
    react(); step();

    // Error on unit 3 with unit 0 competing, ptr at 3
    load(3, 32'h55, 5'd7, 1);
    load(0, 32'hABCD, 5'd9, 0);
    step();
    chk("err_clear", u_clear, 4'b1000);
    chk("err_we", wb_we, 1'b0);
    chk("err_exc_valid", exc_valid, 1'b1);
    chk("err_exc_unit", exc_unit, 2'd3);
    chk("err_exc_rd", exc_rd, 5'd7);
    chk("err_halted", halted, 1'b1);
    react();
    for (int k = 0; k < 3; k++) begin
      step();
      chk("halt_no_grant", u_clear, 4'b0000);
    end
    exc_ack = 1; step(); exc_ack = 0;
    chk("ack_exc_valid", exc_valid, 1'b0);
    chk("ack_clear", u_clear, 4'b0000);
    step();
    chk("resume_grant0", u_clear, 4'b0001);
    chk("resume_data", wb_data, 32'hABCD);
    react(); step();

    // Reset mid-burst
    for (int i = 0; i < 3; i++) load(i, 32'h200 + i, RW'(i + 10), 0);
    step(); react();
    rst = 1; step(); rst = 0;
    chk("midrst_clear", u_clear, 4'b0000);
    chk("midrst_we", wb_we, 1'b0);
    load(0, 32'h300, 5'd12, 0);
    step();
    chk("midrst_first0", u_clear, 4'b0001);
    react();
    for (int k = 0; k < 3; k++) begin step(); react(); end

`ifdef COMMIT_ARBITER_STATS_EN
    do_reset();
    for (int i = 0; i < 3; i++) load(i, 32'h400 + i, RW'(i + 1), 0);
    for (int k = 0; k < 4; k++) begin step(); react(); end
    chk("stats_commits3", stat_commits, 32'd3);
    chk("stats_conflicts2", stat_conflicts, 32'd2);
`endif

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            res_a[i] = $urandom;
            rd_a[i]  = RW'($urandom_range(0, 31));
            err[i]   = ($urandom_range(0, 15) == 0);
            req[i]   = 1;
            valid[i] = ($urandom_range(0, 7) != 0);
          end
        end else if (!valid[i]) begin
          valid[i] = ($urandom_range(0, 3) == 0);
        end
      end
      exc_ack = m_halt ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 199) == 0);
      step();
      react();
    end
    rst = 0; exc_ack = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
